mna_axi_ar_arb: RTL and testbench
=================================

MNA_AXI_AR_ARB -- requirements
Module: mna_axi_ar_arb

Interface
REQ-001 SHALL have one parameter: MAX_OUTS, default 4, maximum outstanding read bursts per requester (range 1..7).
REQ-002 SHALL be clocked on one clock and reset by an asynchronous, active-high reset: i_clk_mna and i_rst_mna.
REQ-003 SHALL have these ports:
  i_clk_mna  in  1  block clock
  i_rst_mna  in  1  async reset, active high
  i_req_arvalid  in  4  per-requester AR request (0=irdma, 1=prdma, 2=wrdma, 3=owdma)
  i_req_araddr  in  128  4x32 burst start addresses, requester k at [32k+31:32k]
  i_req_arlen  in  32  4x8 burst lengths, requester k at [8k+7:8k]
  o_req_arready  out  4  one-hot AR acceptance pulse per requester
  o_arvalid  out  1  AR valid to mna2main
  i_arready  in  1  AR ready from mna2main
  o_arid  out  2  ARID, equal to the granted requester index
  o_araddr  out  32  granted address
  o_arlen  out  8  granted length
  i_rvalid  in  1  R valid from mna2main
  i_rid  in  2  R ID
  i_rlast  in  1  R last beat
  o_rready  out  1  R ready to mna2main
  o_req_rvalid  out  4  routed R valid per requester
  i_req_rready  in  4  per-requester R ready
  o_outs_busy  out  1  high while any outstanding counter is nonzero
  o_err_unexp  out  1  sticky error: R last beat arrived for an ID with zero outstanding
  i_err_clr  in  1  clears o_err_unexp

Function
REQ-004 SHALL implement the states IDLE and ISSUE.
REQ-005 IDLE -> ISSUE in the cycle after at least one eligible requester exists; eligible means i_req_arvalid[k]=1 and outs_cnt[k] < MAX_OUTS.
REQ-006 SHALL arbitrate round-robin, searching from index (last_grant+1) mod 4; last_grant resets to 3, so requester 0 has first priority.
REQ-007 On entering ISSUE, o_arid, o_araddr and o_arlen SHALL be registered from the winner, and o_arvalid SHALL be 1; first o_arvalid occurs exactly 1 cycle after the request is seen.
REQ-008 In ISSUE, o_arvalid and the AR payload SHALL be held stable until i_arready=1; the handshake cycle returns the state to IDLE.
REQ-009 o_req_arready[winner] SHALL be a combinational 1-cycle pulse equal to o_arvalid & i_arready; all other bits SHALL be 0.
REQ-010 Requesters SHALL hold i_req_arvalid and payload until o_req_arready; a request deasserted during ISSUE does not cancel the issued AR.
REQ-011 At most one AR SHALL be in flight on the AR channel; the next grant takes effect no earlier than the cycle after the handshake.
REQ-012 Each outs_cnt[k] (3 bits) SHALL increment on the AR handshake for ID k and decrement on i_rvalid & o_rready & i_rlast with i_rid=k; when both happen in the same cycle it SHALL be unchanged.
REQ-013 R routing SHALL be combinational: o_req_rvalid[i_rid]=i_rvalid, other bits 0; o_rready=i_req_rready[i_rid].
REQ-014 A last beat for ID k with outs_cnt[k]=0 SHALL leave the counter at 0 (no wrap) and set o_err_unexp on the next clock.
REQ-015 i_err_clr SHALL clear o_err_unexp on the next clock; a simultaneous new error takes priority and keeps it set.
REQ-016 o_outs_busy SHALL be the registered OR of the four counters being nonzero.

Reset
REQ-017 While i_rst_mna=1, the state SHALL be IDLE, and o_arvalid, o_arid, o_araddr, o_arlen, all outs_cnt, o_outs_busy and o_err_unexp SHALL be 0, with last_grant=3.
REQ-018 Reset asserted during ISSUE SHALL drop o_arvalid immediately (asynchronously); any bursts in flight are discarded, and ensuring the fabric is quiescent is the system's responsibility.

Structure
REQ-019 Shared package mna_pkg SHALL hold the NUM_REQ=4 constant, the requester index constants (IRDMA=0, PRDMA=1, WRDMA=2, OWDMA=3) and the IDLE/ISSUE state enum.
REQ-020 Round-robin selection SHALL be a single sub-module, mna_rr_arb (inputs: request vector and last_grant; outputs: one-hot grant and index).

Verification
REQ-021 Single request: req0 addr 0x1000, len 7, with i_arready=1 -> o_arvalid rises 1 cycle later with arid=0, addr 0x1000, len 7; o_req_arready[0] pulses once.
REQ-022 All four requesting continuously -> grant order 0,1,2,3,0; with i_arready stalled 5 cycles, the payload is held constant.
REQ-023 MAX_OUTS=4 with no R returns -> req1 is granted 4 times, then skipped; after one rlast with rid=1 it is granted again.
REQ-024 AR handshake for id2 coincides with an rlast for id2 -> outs_cnt[2] is unchanged; o_req_rvalid=4'b0100 during the beat.
REQ-025 rlast with rid=3 while outs_cnt[3]=0 -> o_err_unexp=1 and the counter stays 0; i_err_clr clears it the next cycle.
REQ-026 Reset asserted mid-ISSUE -> o_arvalid=0 immediately, all counters 0, and after reset release req0 wins first.

Source files
------------

// File: rtl/mna_pkg.sv
// Shared constants and types for the MNA AXI read-address arbiter.
// Requester indices double as the ARID driven onto the fabric.
package mna_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  localparam logic [IDX_W-1:0] IRDMA = 2'd0;
  localparam logic [IDX_W-1:0] PRDMA = 2'd1;
  localparam logic [IDX_W-1:0] WRDMA = 2'd2;
  localparam logic [IDX_W-1:0] OWDMA = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } ar_state_e;

  function automatic logic [NUM_REQ-1:0] idx2oh(
    input logic [IDX_W-1:0] idx
  );
    idx2oh      = '0;
    idx2oh[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/mna_rr_arb.sv
// Round-robin picker: scans from last_i+1 upward, wrapping mod NUM_REQ.
// idx_o holds last_i when nothing is requesting.
module mna_rr_arb
  import mna_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   last_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    gnt_o = '0;
    idx_o = last_i;
    cand  = last_i;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = last_i + IDX_W'(i);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

endmodule

// File: rtl/mna_axi_ar_arb.sv
// Four-way AXI AR arbiter with per-ID outstanding tracking and R routing.
// One AR in flight at a time; ARID is the requester index.
module mna_axi_ar_arb
  import mna_pkg::*;
#(
  parameter int MAX_OUTS = 4
) (
  input  logic                 i_clk_mna,
  input  logic                 i_rst_mna,
  input  logic [NUM_REQ-1:0]   i_req_arvalid,
  input  logic [NUM_REQ*32-1:0] i_req_araddr,
  input  logic [NUM_REQ*8-1:0] i_req_arlen,
  output logic [NUM_REQ-1:0]   o_req_arready,
  output logic                 o_arvalid,
  input  logic                 i_arready,
  output logic [IDX_W-1:0]     o_arid,
  output logic [31:0]          o_araddr,
  output logic [7:0]           o_arlen,
  input  logic                 i_rvalid,
  input  logic [IDX_W-1:0]     i_rid,
  input  logic                 i_rlast,
  output logic                 o_rready,
  output logic [NUM_REQ-1:0]   o_req_rvalid,
  input  logic [NUM_REQ-1:0]   i_req_rready,
  output logic                 o_outs_busy,
  output logic                 o_err_unexp,
  input  logic                 i_err_clr
);

  localparam logic [2:0] MAX_C = 3'(MAX_OUTS);

  ar_state_e        state_q, state_d;
  logic [IDX_W-1:0] last_q;
  logic [IDX_W-1:0] arid_q;
  logic [31:0]      araddr_q;
  logic [7:0]       arlen_q;
  logic [2:0]       cnt_q [NUM_REQ];
  logic [2:0]       cnt_d [NUM_REQ];
  logic             busy_q, busy_d;
  logic             err_q, err_d;

  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] win_gnt;
  logic [IDX_W-1:0]   win_idx;
  logic               take;
  logic               ar_hs;
  logic               r_last_hs;
  logic               unexp;

  always_comb begin
    elig = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      elig[k] = i_req_arvalid[k] && (cnt_q[k] < MAX_C);
    end
  end

  mna_rr_arb u_rr (
    .req_i  (elig),
    .last_i (last_q),
    .gnt_o  (win_gnt),
    .idx_o  (win_idx)
  );

  assign take = (state_q == IDLE) && (|win_gnt);

  always_ff @(posedge i_clk_mna or posedge i_rst_mna) begin
    if (i_rst_mna) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (|win_gnt) state_d = ISSUE;
      ISSUE:   if (i_arready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_arvalid     = (state_q == ISSUE);
    o_req_arready = '0;
    if (o_arvalid && i_arready) begin
      o_req_arready = idx2oh(arid_q);
    end
  end

  // Payload is captured once on grant and frozen for the whole ISSUE.
  always_ff @(posedge i_clk_mna or posedge i_rst_mna) begin
    if (i_rst_mna) begin
      last_q   <= OWDMA;
      arid_q   <= '0;
      araddr_q <= '0;
      arlen_q  <= '0;
    end else if (take) begin
      last_q   <= win_idx;
      arid_q   <= win_idx;
      araddr_q <= i_req_araddr[{win_idx, 5'd0} +: 32];
      arlen_q  <= i_req_arlen[{win_idx, 3'd0} +: 8];
    end
  end

  assign o_arid   = arid_q;
  assign o_araddr = araddr_q;
  assign o_arlen  = arlen_q;

  assign o_rready     = i_req_rready[i_rid];
  assign o_req_rvalid = i_rvalid ? idx2oh(i_rid) : '0;

  assign ar_hs     = o_arvalid && i_arready;
  assign r_last_hs = i_rvalid && o_rready && i_rlast;
  assign unexp     = r_last_hs && (cnt_q[i_rid] == 3'd0);

  // A last beat on an empty counter is flagged and never decrements.
  always_comb begin
    busy_d = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cnt_d[k] = cnt_q[k];
      if (ar_hs && (arid_q == IDX_W'(k))) begin
        cnt_d[k] = cnt_d[k] + 3'd1;
      end
      if (r_last_hs && (i_rid == IDX_W'(k)) && (cnt_q[k] != 3'd0)) begin
        cnt_d[k] = cnt_d[k] - 3'd1;
      end
      busy_d = busy_d | (cnt_d[k] != 3'd0);
    end
  end

  always_comb begin
    err_d = err_q;
    if (unexp) begin
      err_d = 1'b1;
    end else if (i_err_clr) begin
      err_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk_mna or posedge i_rst_mna) begin
    if (i_rst_mna) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cnt_q[k] <= '0;
      end
      busy_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cnt_q[k] <= cnt_d[k];
      end
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  assign o_outs_busy = busy_q;
  assign o_err_unexp = err_q;

endmodule

// File: tb/tb_mna_axi_ar_arb.sv
// Self-checking bench for mna_axi_ar_arb: R-routing vector table,
// directed corner sequences and a randomized run against a reference model.
module tb_mna_axi_ar_arb;

  localparam int MAXO = 4;

  logic         clk;
  logic         rst;
  logic [3:0]   arvalid;
  logic [127:0] araddr;
  logic [31:0]  arlen;
  logic [3:0]   req_arready;
  logic         o_arvalid;
  logic         arready;
  logic [1:0]   o_arid;
  logic [31:0]  o_araddr;
  logic [7:0]   o_arlen;
  logic         rvalid;
  logic [1:0]   rid;
  logic         rlast;
  logic         o_rready;
  logic [3:0]   o_req_rvalid;
  logic [3:0]   req_rready;
  logic         o_busy;
  logic         o_err;
  logic         err_clr;

  mna_axi_ar_arb #(.MAX_OUTS(MAXO)) dut (
    .i_clk_mna     (clk),
    .i_rst_mna     (rst),
    .i_req_arvalid (arvalid),
    .i_req_araddr  (araddr),
    .i_req_arlen   (arlen),
    .o_req_arready (req_arready),
    .o_arvalid     (o_arvalid),
    .i_arready     (arready),
    .o_arid        (o_arid),
    .o_araddr      (o_araddr),
    .o_arlen       (o_arlen),
    .i_rvalid      (rvalid),
    .i_rid         (rid),
    .i_rlast       (rlast),
    .o_rready      (o_rready),
    .o_req_rvalid  (o_req_rvalid),
    .i_req_rready  (req_rready),
    .o_outs_busy   (o_busy),
    .o_err_unexp   (o_err),
    .i_err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int grants[$];

  // Reference model: outstanding counts per ID, one pending AR, rr pointer.
  int          mcnt [4];
  bit          mpend;
  int          mid;
  logic [31:0] maddr;
  logic [7:0]  mlen;
  int          mlast;
  bit          merr;
  bit          m_hs;
  int          m_hs_id;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 4; k++) mcnt[k] = 0;
    mpend = 0; mid = 0; maddr = '0; mlen = '0;
    mlast = 3; merr = 0; m_hs = 0; m_hs_id = 0;
  endtask

  task automatic m_update();
    int  nc [4];
    bit  newerr;
    bit  rl;
    if (rst) begin
      m_reset();
      return;
    end
    for (int k = 0; k < 4; k++) nc[k] = mcnt[k];
    newerr = 0;
    m_hs = mpend && arready;
    m_hs_id = mid;
    rl = rvalid && req_rready[rid] && rlast;
    if (rl) begin
      if (mcnt[rid] == 0) newerr = 1;
      else nc[rid] = nc[rid] - 1;
    end
    if (m_hs) nc[mid] = nc[mid] + 1;
    if (!mpend) begin
      for (int j = 1; j <= 4; j++) begin
        int k;
        k = (mlast + j) % 4;
        if (!mpend && arvalid[k] && mcnt[k] < MAXO) begin
          mpend = 1; mid = k; mlast = k;
          maddr = araddr[k*32 +: 32];
          mlen  = arlen[k*8 +: 8];
        end
      end
    end else if (m_hs) begin
      mpend = 0;
    end
    merr = newerr ? 1'b1 : (err_clr ? 1'b0 : merr);
    for (int k = 0; k < 4; k++) mcnt[k] = nc[k];
  endtask

  task automatic check_all();
    logic [3:0] e_ardy;
    logic [3:0] e_rv;
    bit         e_busy;
    e_ardy = '0;
    if (mpend && arready) e_ardy[mid] = 1'b1;
    e_rv = '0;
    if (rvalid) e_rv[rid] = 1'b1;
    e_busy = 0;
    for (int k = 0; k < 4; k++) if (mcnt[k] != 0) e_busy = 1;
    chk("arvalid", o_arvalid, mpend);
    if (mpend) begin
      chk("arid", o_arid, mid);
      chk("araddr", o_araddr, maddr);
      chk("arlen", o_arlen, mlen);
    end
    chk("req_arready", req_arready, e_ardy);
    chk("req_rvalid", o_req_rvalid, e_rv);
    chk("rready", o_rready, req_rready[rid]);
    chk("outs_busy", o_busy, e_busy);
    chk("err_unexp", o_err, merr);
  endtask

  // Called at a negedge with inputs already set; returns at the next negedge.
  task automatic cycle();
    #1;
    check_all();
    if (o_arvalid && arready) grants.push_back(int'(o_arid));
    @(posedge clk);
    m_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    arvalid = '0; araddr = '0; arlen = '0; arready = 1'b0;
    rvalid = 1'b0; rid = '0; rlast = 1'b0; req_rready = 4'hF;
    err_clr = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    m_reset();
    cycle();
    cycle();
    rst = 1'b0;
    grants.delete();
  endtask

  typedef struct {
    logic       rv;
    logic [1:0] id;
    logic [3:0] rr;
    logic [3:0] exp_rv;
    logic       exp_rr;
  } rvec_t;

  rvec_t vt [8];
  int    exp_order [5];

  initial begin
    vt[0] = '{1'b1, 2'd0, 4'b0001, 4'b0001, 1'b1};
    vt[1] = '{1'b1, 2'd1, 4'b0001, 4'b0010, 1'b0};
    vt[2] = '{1'b1, 2'd2, 4'b0100, 4'b0100, 1'b1};
    vt[3] = '{1'b1, 2'd3, 4'b0111, 4'b1000, 1'b0};
    vt[4] = '{1'b0, 2'd3, 4'b1000, 4'b0000, 1'b1};
    vt[5] = '{1'b0, 2'd1, 4'b0000, 4'b0000, 1'b0};
    vt[6] = '{1'b1, 2'd3, 4'b1111, 4'b1000, 1'b1};
    vt[7] = '{1'b1, 2'd2, 4'b1011, 4'b0100, 1'b0};
    exp_order = '{0, 1, 2, 3, 0};

    rst = 1'b1;
    idle_inputs();
    m_reset();
    @(negedge clk);
    #1;
    chk("rst_arvalid", o_arvalid, 0);
    chk("rst_arid", o_arid, 0);
    chk("rst_araddr", o_araddr, 0);
    chk("rst_arlen", o_arlen, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err, 0);
    @(negedge clk);
    do_reset();

    // R routing table, rlast low so counters are untouched
    for (int i = 0; i < 8; i++) begin
      rvalid = vt[i].rv; rid = vt[i].id; req_rready = vt[i].rr;
      #1;
      chk("tbl_rvalid", o_req_rvalid, vt[i].exp_rv);
      chk("tbl_rready", o_rready, vt[i].exp_rr);
      cycle();
    end
    idle_inputs();

    // Single request
    do_reset();
    arvalid = 4'b0001; araddr[31:0] = 32'h1000; arlen[7:0] = 8'd7;
    arready = 1'b1;
    #1;
    chk("r21_pre_arvalid", o_arvalid, 0);
    cycle();
    #1;
    chk("r21_arvalid", o_arvalid, 1);
    chk("r21_arid", o_arid, 0);
    chk("r21_araddr", o_araddr, 32'h1000);
    chk("r21_arlen", o_arlen, 7);
    chk("r21_pulse", req_arready, 4'b0001);
    cycle();
    arvalid = '0;
    #1;
    chk("r21_after_arvalid", o_arvalid, 0);
    chk("r21_after_pulse", req_arready, 0);
    cycle();
    cycle();
    chk("r21_grant_count", grants.size(), 1);

    // All four requesting, with a stalled first AR
    do_reset();
    arvalid = 4'hF;
    for (int k = 0; k < 4; k++) begin
      araddr[k*32 +: 32] = 32'hA000 + 32'(k) * 32'h100;
      arlen[k*8 +: 8] = 8'(k + 1);
    end
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("r22_hold_valid", o_arvalid, 1);
      chk("r22_hold_addr", o_araddr, 32'hA000);
      chk("r22_hold_len", o_arlen, 1);
    end
    arready = 1'b1;
    for (int i = 0; i < 10; i++) cycle();
    arready = 1'b0;
    chk("r22_grant_count", grants.size() >= 5, 1);
    if (grants.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk("r22_order", grants[i], exp_order[i]);
    end

    // Outstanding limit on requester 1
    do_reset();
    arvalid = 4'b0010; araddr[63:32] = 32'hB000; arlen[15:8] = 8'd3;
    arready = 1'b1;
    for (int i = 0; i < 14; i++) cycle();
    chk("r23_grant_count", grants.size(), 4);
    foreach (grants[i]) chk("r23_id", grants[i], 1);
    chk("r23_busy", o_busy, 1);
    rvalid = 1'b1; rid = 2'd1; rlast = 1'b1;
    cycle();
    rvalid = 1'b0; rlast = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    chk("r23_regrant", grants.size(), 5);

    // AR handshake and last beat for the same ID in one cycle
    do_reset();
    arvalid = 4'b0100; araddr[95:64] = 32'hC000; arready = 1'b1;
    cycle();
    cycle();
    arready = 1'b0;
    cycle();
    arready = 1'b1; rvalid = 1'b1; rid = 2'd2; rlast = 1'b1;
    #1;
    chk("r24_rvalid", o_req_rvalid, 4'b0100);
    chk("r24_pulse", req_arready, 4'b0100);
    cycle();
    arvalid = '0; rvalid = 1'b0; rlast = 1'b0;
    cycle();
    chk("r24_busy_kept", o_busy, 1);
    rvalid = 1'b1; rid = 2'd2; rlast = 1'b1;
    cycle();
    rvalid = 1'b0; rlast = 1'b0;
    cycle();
    chk("r24_busy_drained", o_busy, 0);
    chk("r24_no_err", o_err, 0);

    // Unexpected last beat, clear, and set-over-clear priority
    do_reset();
    rvalid = 1'b1; rid = 2'd3; rlast = 1'b1;
    cycle();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    chk("r25_err_set", o_err, 1);
    chk("r25_busy", o_busy, 0);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    #1;
    chk("r25_err_clr", o_err, 0);
    rvalid = 1'b1; rlast = 1'b1; err_clr = 1'b1;
    cycle();
    rvalid = 1'b0; rlast = 1'b0; err_clr = 1'b0;
    #1;
    chk("r25_err_prio", o_err, 1);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    arvalid = 4'b1000; arready = 1'b1;
    cycle();
    cycle();
    arvalid = '0;
    #1;
    chk("r25_busy_one", o_busy, 1);
    rvalid = 1'b1; rid = 2'd3; rlast = 1'b1;
    cycle();
    rvalid = 1'b0; rlast = 1'b0;
    #1;
    chk("r25_busy_zero", o_busy, 0);
    chk("r25_err_zero", o_err, 0);

    // Reset in the middle of ISSUE
    do_reset();
    arvalid = 4'b0011; arready = 1'b1;
    araddr[31:0] = 32'hD000; araddr[63:32] = 32'hD100;
    cycle();
    cycle();
    arready = 1'b0;
    cycle();
    #1;
    chk("r26_issue", o_arvalid, 1);
    chk("r26_issue_id", o_arid, 1);
    #1;
    rst = 1'b1;
    m_reset();
    #1;
    chk("r26_async_drop", o_arvalid, 0);
    chk("r26_busy", o_busy, 0);
    cycle();
    rst = 1'b0;
    grants.delete();
    arready = 1'b1;
    cycle();
    cycle();
    chk("r26_grant_seen", grants.size() >= 1, 1);
    if (grants.size() >= 1) chk("r26_first", grants[0], 0);

    // Randomized traffic against the model
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      for (int k = 0; k < 4; k++) begin
        if (!arvalid[k] && $urandom_range(0, 2) == 0) begin
          arvalid[k] = 1'b1;
          araddr[k*32 +: 32] = $urandom;
          arlen[k*8 +: 8] = 8'($urandom);
        end
      end
      arready    = ($urandom_range(0, 9) < 6);
      rvalid     = 1'($urandom);
      rid        = 2'($urandom);
      rlast      = 1'($urandom);
      req_rready = 4'($urandom);
      err_clr    = ($urandom_range(0, 15) == 0);
      cycle();
      if (m_hs) arvalid[m_hs_id] = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
